// File: rtl/mm_control_unit.sv
// mm_control_unit: multi-cycle Moore control FSM for the memory-to-memory
// datapath. It sequences opcode fetch, operand-address fetch, operand loads,
// execute and writeback, one state per cycle.
// Build option: define MM_CU_BRANCH_EN to compile BEQ support (CMP/BR states).
// Without it, opcode 0x08 is illegal and normOrBranch stays 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | post-reset; holds one full cycle before the first fetch
// FETCH_OP | load opcode register, PC += 1
// FETCH_A  | load operand-A address, PC += 1
// FETCH_B  | load operand-B address, PC += 1, decode opcode legality
// LOAD_A   | read operand A from memory
// LOAD_B   | read operand B from memory (skipped by ADDI)
// EXEC     | register-register ALU op, result into dest
// EXEC_I   | ADDI: A + immediate into dest
// WB       | write dest back to memory, PC += 1, instruction done
// CMP      | BEQ: subtract operands to set isTrue
// BR       | BEQ: load branch target when isTrue, instruction done
// HALT     | illegal opcode seen; only reset leaves this state

module mm_control_unit (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] Opout,
   input  logic       isTrue,
   output logic       inputPC,
   output logic       writeMem,
   output logic       regOrPC,
   output logic       valA,
   output logic       normOrBranch,
   output logic [1:0] memAddr,
   output logic [1:0] memWriteData,
   output logic [1:0] ALUsrca,
   output logic [1:0] ALUsrcb,
   output logic [3:0] ALUOp,
   output logic       writeA,
   output logic       writeB,
   output logic       writeDest,
   output logic       writeOp,
   output logic       WEpc,
   output logic       instr_done,
   output logic       halted
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH_OP = 4'd1,
      FETCH_A  = 4'd2,
      FETCH_B  = 4'd3,
      LOAD_A   = 4'd4,
      LOAD_B   = 4'd5,
      EXEC     = 4'd6,
      EXEC_I   = 4'd7,
      WB       = 4'd8,
      HALT     = 4'd11
`ifdef MM_CU_BRANCH_EN
      ,
      CMP      = 4'd9,
      BR       = 4'd10
`endif
   } state_t;

   state_t state;
   state_t nextState;
   logic   started;
   logic   opLegal;
   logic   isAddi;

   // Reserved for future jump instructions.
   assign inputPC = 1'b0;
   assign valA    = 1'b0;

   assign isAddi = (Opout == 8'h04);

`ifdef MM_CU_BRANCH_EN
   logic isBeq;
   assign isBeq   = (Opout == 8'h08);
   assign opLegal = (Opout <= 8'h04) || isBeq;
`else
   logic unusedIsTrue;
   assign unusedIsTrue = isTrue;
   assign opLegal      = (Opout <= 8'h04);
`endif

   // Marks that one full cycle has elapsed since reset release, so IDLE
   // lasts a whole cycle regardless of where the release lands.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) started <= 1'b0;
      else        started <= 1'b1;
   end

   // State register.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      nextState    = state;
      writeMem     = 1'b0;
      regOrPC      = 1'b0;
      normOrBranch = 1'b0;
      memAddr      = 2'b00;
      memWriteData = 2'b00;
      ALUsrca      = 2'b00;
      ALUsrcb      = 2'b00;
      ALUOp        = 4'b0000;
      writeA       = 1'b0;
      writeB       = 1'b0;
      writeDest    = 1'b0;
      writeOp      = 1'b0;
      WEpc         = 1'b0;
      instr_done   = 1'b0;
      halted       = 1'b0;
      case (state)
         IDLE: begin
            if (started) nextState = FETCH_OP;
         end
         FETCH_OP: begin
            writeOp   = 1'b1;
            WEpc      = 1'b1;
            ALUsrca   = 2'b01;
            ALUsrcb   = 2'b01;
            nextState = FETCH_A;
         end
         FETCH_A: begin
            writeA    = 1'b1;
            WEpc      = 1'b1;
            ALUsrca   = 2'b01;
            ALUsrcb   = 2'b10;
            nextState = FETCH_B;
         end
         FETCH_B: begin
            writeB    = 1'b1;
            WEpc      = 1'b1;
            ALUsrca   = 2'b01;
            ALUsrcb   = 2'b10;
            nextState = opLegal ? LOAD_A : HALT;
         end
         LOAD_A: begin
            regOrPC   = 1'b1;
            memAddr   = 2'b00;
            writeA    = 1'b1;
            nextState = isAddi ? EXEC_I : LOAD_B;
         end
         LOAD_B: begin
            regOrPC   = 1'b1;
            memAddr   = 2'b01;
            writeB    = 1'b1;
`ifdef MM_CU_BRANCH_EN
            nextState = isBeq ? CMP : EXEC;
`else
            nextState = EXEC;
`endif
         end
         EXEC: begin
            writeA    = 1'b1;
            writeDest = 1'b1;
            // Only ADD/SUB/OR/AND reach EXEC; their low bits are the ALU code.
            ALUOp     = {2'b00, Opout[1:0]};
            nextState = WB;
         end
         EXEC_I: begin
            writeDest = 1'b1;
            nextState = WB;
         end
         WB: begin
            writeMem     = 1'b1;
            regOrPC      = 1'b1;
            memAddr      = 2'b10;
            memWriteData = 2'b01;
            WEpc         = 1'b1;
            ALUsrca      = 2'b01;
            ALUsrcb      = 2'b10;
            instr_done   = 1'b1;
            nextState    = FETCH_OP;
         end
`ifdef MM_CU_BRANCH_EN
         CMP: begin
            ALUOp     = 4'b0001;
            nextState = BR;
         end
         BR: begin
            normOrBranch = 1'b1;
            WEpc         = isTrue;
            instr_done   = 1'b1;
            nextState    = FETCH_OP;
         end
`endif
         HALT: begin
            halted    = 1'b1;
            nextState = HALT;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mm_control_unit.sv
// Testbench for mm_control_unit: table-driven opcode cases, hand-written
// reset sequences, and random instruction streams checked cycle by cycle
// against an expected-output list built from the per-opcode step rules.
module tb_mm_control_unit;

   logic       CLK = 1'b0;
   logic       reset;
   logic [7:0] Opout;
   logic       isTrue;
   logic       inputPC, writeMem, regOrPC, valA, normOrBranch;
   logic [1:0] memAddr, memWriteData, ALUsrca, ALUsrcb;
   logic [3:0] ALUOp;
   logic       writeA, writeB, writeDest, writeOp, WEpc, instr_done, halted;

   int checks = 0;
   int errors = 0;

`ifdef MM_CU_BRANCH_EN
   localparam bit BRANCH_EN = 1'b1;
`else
   localparam bit BRANCH_EN = 1'b0;
`endif

   mm_control_unit dut (
      .CLK(CLK), .reset(reset), .Opout(Opout), .isTrue(isTrue),
      .inputPC(inputPC), .writeMem(writeMem), .regOrPC(regOrPC), .valA(valA),
      .normOrBranch(normOrBranch), .memAddr(memAddr), .memWriteData(memWriteData),
      .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb), .ALUOp(ALUOp),
      .writeA(writeA), .writeB(writeB), .writeDest(writeDest), .writeOp(writeOp),
      .WEpc(WEpc), .instr_done(instr_done), .halted(halted)
   );

   always #5 CLK = ~CLK;

   logic [23:0] actVec;
   assign actVec = {inputPC, writeMem, regOrPC, valA, normOrBranch, memAddr,
                    memWriteData, ALUsrca, ALUsrcb, ALUOp, writeA, writeB,
                    writeDest, writeOp, WEpc, instr_done, halted};

   function automatic logic [23:0] cv(input logic wm, rp, nb,
                                      input logic [1:0] ma, mwd, sa, sb,
                                      input logic [3:0] op,
                                      input logic wa, wbb, wd, wo, we, id, h);
      return {1'b0, wm, rp, 1'b0, nb, ma, mwd, sa, sb, op, wa, wbb, wd, wo, we, id, h};
   endfunction

   function automatic bit isLegal(input logic [7:0] op);
      return (op <= 8'h04) || (BRANCH_EN && op == 8'h08);
   endfunction

   function automatic logic [3:0] aluFor(input logic [7:0] op);
      case (op)
         8'h00:   return 4'b0000;
         8'h01:   return 4'b0001;
         8'h02:   return 4'b0010;
         8'h03:   return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic int expLenFor(input logic [7:0] op);
      if (!isLegal(op)) return 0;
      return (op == 8'h04) ? 6 : 7;
   endfunction

   logic [23:0] expQ[$];

   // Expected outputs per cycle from FETCH_OP onward for one instruction.
   task automatic buildExp(input logic [7:0] op, input logic tr);
      expQ.delete();
      expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd1,2'd1, 4'd0, 0,0,0,1,1,0,0));
      expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd1,2'd2, 4'd0, 1,0,0,0,1,0,0));
      expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd1,2'd2, 4'd0, 0,1,0,0,1,0,0));
      if (!isLegal(op)) begin
         repeat (4) expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 0,0,0,0,0,0,1));
         return;
      end
      expQ.push_back(cv(0,1,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 1,0,0,0,0,0,0));
      if (op == 8'h04) begin
         expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 0,0,1,0,0,0,0));
      end else begin
         expQ.push_back(cv(0,1,0, 2'd1,2'd0,2'd0,2'd0, 4'd0, 0,1,0,0,0,0,0));
         if (op == 8'h08) begin
            expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd1, 0,0,0,0,0,0,0));
            expQ.push_back(cv(0,0,1, 2'd0,2'd0,2'd0,2'd0, 4'd0, 0,0,0,0,tr,1,0));
            return;
         end
         expQ.push_back(cv(0,0,0, 2'd0,2'd0,2'd0,2'd0, aluFor(op), 1,0,1,0,0,0,0));
      end
      expQ.push_back(cv(1,1,0, 2'd2,2'd1,2'd1,2'd2, 4'd0, 0,0,0,0,1,1,0));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Assert reset asynchronously mid-cycle, hold 2 edges, release at negedge,
   // then check the one IDLE cycle that precedes the first fetch.
   task automatic doReset();
      reset = 1'b0;
      #1 chk("rst_async", {8'h0, actVec}, 32'h0);
      repeat (2) begin
         @(posedge CLK); #2;
         chk("rst_hold", {8'h0, actVec}, 32'h0);
      end
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK); #2;
      chk("idle_after_rel", {8'h0, actVec}, 32'h0);
   endtask

   task automatic runInstr(input logic [7:0] op, input logic tr, output int doneAt);
      buildExp(op, tr);
      Opout  = op;
      isTrue = tr;
      doneAt = 0;
      for (int i = 0; i < expQ.size(); i++) begin
         @(posedge CLK); #2;
         chk($sformatf("vec op=%h tr=%0d cyc=%0d", op, tr, i + 1), {8'h0, actVec}, {8'h0, expQ[i]});
         if (instr_done === 1'b1 && doneAt == 0) doneAt = i + 1;
      end
   endtask

   typedef struct {
      logic [7:0] op;
      logic       tr;
      int         expLen;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int doneAt;
      logic [7:0] op;
      logic tr;
      int r;

      tbl[0] = '{8'h00, 1'b0, 7};
      tbl[1] = '{8'h01, 1'b1, 7};
      tbl[2] = '{8'h02, 1'b0, 7};
      tbl[3] = '{8'h03, 1'b1, 7};
      tbl[4] = '{8'h04, 1'b0, 6};
      tbl[5] = '{8'h08, 1'b1, BRANCH_EN ? 7 : 0};
      tbl[6] = '{8'h08, 1'b0, BRANCH_EN ? 7 : 0};
      tbl[7] = '{8'hFF, 1'b0, 0};
      tbl[8] = '{8'h05, 1'b1, 0};

      reset  = 1'b0;
      Opout  = 8'hA5;
      isTrue = 1'b1;
      #3;
      doReset();

      // Table-driven opcodes; back-to-back legal ones check the no-bubble rule.
      for (int k = 0; k < 9; k++) begin
         runInstr(tbl[k].op, tbl[k].tr, doneAt);
         chk($sformatf("len op=%h", tbl[k].op), doneAt, tbl[k].expLen);
         if (tbl[k].expLen == 0) doReset();
      end

      // Reset pulled mid-EXEC of an ADD: immediate IDLE, no writeback ever.
      Opout  = 8'h00;
      isTrue = 1'b0;
      repeat (6) @(posedge CLK);
      #2;
      chk("pre_rst_exec", {8'h0, actVec},
          {8'h0, cv(0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 1,0,1,0,0,0,0)});
      reset = 1'b0;
      #1 chk("rst_mid_exec", {8'h0, actVec}, 32'h0);
      repeat (3) begin
         @(posedge CLK); #2;
         chk("no_wb_after_rst", {31'h0, writeMem}, 32'h0);
      end
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK); #2;
      chk("idle_after_mid_rst", {8'h0, actVec}, 32'h0);
      runInstr(8'h00, 1'b0, doneAt);
      chk("len add_after_rst", doneAt, 7);

      // Random instruction stream.
      repeat (40) begin
         r = $urandom_range(0, 7);
         if (r <= 4)      op = r[7:0];
         else if (r <= 6) op = 8'h08;
         else             op = 8'($urandom_range(0, 255));
         tr = 1'($urandom_range(0, 1));
         runInstr(op, tr, doneAt);
         chk($sformatf("rlen op=%h", op), doneAt, expLenFor(op));
         if (!isLegal(op)) doReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
